// File: rtl/cmos_timing_gen.sv
// CMOS sensor style timing generator: VSYNC, vertical blank, then HREF lines.
// Nested pixel/line counters advance on pix_en; all outputs are registered.
module cmos_timing_gen #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 12
) (
    input  logic              sys_clock,
    input  logic              reset,
    input  logic              pix_en,
    input  logic              start,
    input  logic              stop,
    input  logic [CNT_W-1:0]  h_size,
    input  logic [CNT_W-1:0]  v_size,
    input  logic [CNT_W-1:0]  h_blank,
    input  logic [CNT_W-1:0]  v_blank,
    input  logic [CNT_W-1:0]  vsync_len,
    input  logic [CNT_W-1:0]  frame_cnt,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] const_val,
    output logic              cmos_href,
    output logic              cmos_vsync,
    output logic [DATA_W-1:0] cmos_data,
    output logic              busy,
    output logic              frame_done,
    output logic              cfg_err
);

    typedef enum logic [1:0] {
        IDLE,
        VSYNC,
        VBLANK,
        ACTIVE
    } state_t;

    localparam logic [CNT_W:0] ONE_W = {{CNT_W{1'b0}}, 1'b1};

    state_t            state;
    logic [CNT_W-1:0]  col;
    logic [CNT_W-1:0]  line_idx;
    logic [CNT_W-1:0]  frm_idx;
    logic              stop_flag;
    logic [DATA_W-1:0] pix_ctr;

    logic [CNT_W-1:0]  r_h_size;
    logic [CNT_W-1:0]  r_v_size;
    logic [CNT_W-1:0]  r_h_blank;
    logic [CNT_W-1:0]  r_v_blank;
    logic [CNT_W-1:0]  r_vsync_len;
    logic [CNT_W-1:0]  r_frame_cnt;
    logic [1:0]        r_mode;
    logic [DATA_W-1:0] r_const_val;

    logic [CNT_W:0]    col_inc;
    logic [CNT_W:0]    line_inc;
    logic [CNT_W:0]    frm_inc;
    logic [CNT_W:0]    line_len;
    logic [CNT_W-1:0]  state_lines;
    logic              line_end;
    logic              state_end;
    logic              run_end;
    logic              cfg_bad;

    state_t            nxt_state;
    logic [CNT_W-1:0]  nxt_col;
    logic [CNT_W-1:0]  nxt_line;
    logic              nxt_href;
    logic [DATA_W-1:0] nxt_data;

    assign cfg_bad = (h_size == '0) || (v_size == '0) || (vsync_len == '0);

    // Position bookkeeping: line ends after h_size+h_blank ticks, a state
    // ends after its line count; the last ACTIVE line closes the frame.
    always_comb begin
        col_inc  = {1'b0, col} + ONE_W;
        line_inc = {1'b0, line_idx} + ONE_W;
        frm_inc  = {1'b0, frm_idx} + ONE_W;
        line_len = {1'b0, r_h_size} + {1'b0, r_h_blank};
        state_lines = '0;
        case (state)
            VSYNC:   state_lines = r_vsync_len;
            VBLANK:  state_lines = r_v_blank;
            ACTIVE:  state_lines = r_v_size;
            default: state_lines = '0;
        endcase
        line_end  = (col_inc == line_len);
        state_end = line_end && (line_inc == {1'b0, state_lines});
        run_end   = stop_flag || stop ||
                    ((r_frame_cnt != '0) && (frm_inc == {1'b0, r_frame_cnt}));
    end

    always_comb begin
        nxt_state = state;
        nxt_col   = col;
        nxt_line  = line_idx;
        if (!line_end) begin
            nxt_col = col_inc[CNT_W-1:0];
        end else begin
            nxt_col = '0;
            if (!state_end) begin
                nxt_line = line_inc[CNT_W-1:0];
            end else begin
                nxt_line = '0;
                case (state)
                    VSYNC:   nxt_state = (r_v_blank != '0) ? VBLANK : ACTIVE;
                    VBLANK:  nxt_state = ACTIVE;
                    ACTIVE:  nxt_state = run_end ? IDLE : VSYNC;
                    default: nxt_state = IDLE;
                endcase
            end
        end
    end

    always_comb begin
        nxt_href = (nxt_state == ACTIVE) && (nxt_col < r_h_size);
        nxt_data = '0;
        unique case (r_mode)
            2'd0: nxt_data = pix_ctr;
            2'd1: nxt_data = DATA_W'(nxt_col);
            2'd2: nxt_data = DATA_W'(nxt_line);
            2'd3: nxt_data = r_const_val;
            default: nxt_data = '0;
        endcase
    end

    always_ff @(posedge sys_clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            col         <= '0;
            line_idx    <= '0;
            frm_idx     <= '0;
            stop_flag   <= 1'b0;
            pix_ctr     <= '0;
            r_h_size    <= '0;
            r_v_size    <= '0;
            r_h_blank   <= '0;
            r_v_blank   <= '0;
            r_vsync_len <= '0;
            r_frame_cnt <= '0;
            r_mode      <= '0;
            r_const_val <= '0;
            cmos_href   <= 1'b0;
            cmos_vsync  <= 1'b0;
            cmos_data   <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (state != IDLE && stop) begin
                stop_flag <= 1'b1;
            end
            if (state == IDLE) begin
                if (start && cfg_bad) begin
                    cfg_err <= 1'b1;
                end else if (start) begin
                    cfg_err     <= 1'b0;
                    r_h_size    <= h_size;
                    r_v_size    <= v_size;
                    r_h_blank   <= h_blank;
                    r_v_blank   <= v_blank;
                    r_vsync_len <= vsync_len;
                    r_frame_cnt <= frame_cnt;
                    r_mode      <= mode;
                    r_const_val <= const_val;
                    state       <= VSYNC;
                    col         <= '0;
                    line_idx    <= '0;
                    frm_idx     <= '0;
                    stop_flag   <= 1'b0;
                    pix_ctr     <= '0;
                    busy        <= 1'b1;
                    cmos_vsync  <= 1'b1;
                    cmos_href   <= 1'b0;
                    cmos_data   <= '0;
                end
            end else if (pix_en) begin
                state      <= nxt_state;
                col        <= nxt_col;
                line_idx   <= nxt_line;
                busy       <= (nxt_state != IDLE);
                cmos_vsync <= (nxt_state == VSYNC);
                cmos_href  <= nxt_href;
                cmos_data  <= nxt_href ? nxt_data : '0;
                if (nxt_href && r_mode == 2'd0) begin
                    pix_ctr <= pix_ctr + 1'b1;
                end
                if (state == ACTIVE && state_end) begin
                    frame_done <= 1'b1;
                    frm_idx    <= frm_inc[CNT_W-1:0];
                    stop_flag  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_cmos_timing_gen.sv
// Bench for cmos_timing_gen: per-tick expected stream built from frame rules,
// compared on every clock edge with directed and randomized runs.
module tb_cmos_timing_gen;

    localparam int DW = 8;
    localparam int CW = 12;

    logic          sys_clock = 1'b0;
    logic          reset     = 1'b1;
    logic          pix_en    = 1'b0;
    logic          start     = 1'b0;
    logic          stop      = 1'b0;
    logic [CW-1:0] h_size    = '0;
    logic [CW-1:0] v_size    = '0;
    logic [CW-1:0] h_blank   = '0;
    logic [CW-1:0] v_blank   = '0;
    logic [CW-1:0] vsync_len = '0;
    logic [CW-1:0] frame_cnt = '0;
    logic [1:0]    mode      = '0;
    logic [DW-1:0] const_val = '0;
    logic          cmos_href;
    logic          cmos_vsync;
    logic [DW-1:0] cmos_data;
    logic          busy;
    logic          frame_done;
    logic          cfg_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int h, v, hb, vb, vs, fc, md, cv;
    } cfg_t;

    typedef struct packed {
        logic          vs;
        logic          hr;
        logic [DW-1:0] d;
        logic          bz;
        logic          fd;
    } obs_t;

    obs_t exp_q[$];
    int   frame_start[$];

    cmos_timing_gen #(.DATA_W(DW), .CNT_W(CW)) dut (
        .sys_clock(sys_clock), .reset(reset), .pix_en(pix_en),
        .start(start), .stop(stop),
        .h_size(h_size), .v_size(v_size),
        .h_blank(h_blank), .v_blank(v_blank),
        .vsync_len(vsync_len), .frame_cnt(frame_cnt),
        .mode(mode), .const_val(const_val),
        .cmos_href(cmos_href), .cmos_vsync(cmos_vsync),
        .cmos_data(cmos_data), .busy(busy),
        .frame_done(frame_done), .cfg_err(cfg_err)
    );

    always #5 sys_clock = ~sys_clock;

    function automatic obs_t mk(bit v, bit h, int d, bit b, bit f);
        obs_t e;
        e.vs = v; e.hr = h; e.d = DW'(d); e.bz = b; e.fd = f;
        return e;
    endfunction

    function automatic obs_t sample();
        return mk(cmos_vsync, cmos_href, int'(cmos_data), busy, frame_done);
    endfunction

    // Expected output after the start edge and after each pix_en edge.
    task automatic build_model(input cfg_t c, input int n);
        int p;
        int L;
        int d;
        bit hr;
        p = 0;
        L = c.h + c.hb;
        exp_q.delete();
        frame_start.delete();
        for (int f = 0; f < n; f++) begin
            frame_start.push_back(exp_q.size());
            for (int t = 0; t < c.vs * L; t++)
                exp_q.push_back(mk(1, 0, 0, 1, (t == 0 && f > 0)));
            for (int t = 0; t < c.vb * L; t++)
                exp_q.push_back(mk(0, 0, 0, 1, 0));
            for (int ln = 0; ln < c.v; ln++) begin
                for (int col = 0; col < L; col++) begin
                    hr = (col < c.h);
                    d = 0;
                    if (hr) begin
                        case (c.md)
                            0: begin d = p % 256; p++; end
                            1: d = col;
                            2: d = ln;
                            default: d = c.cv;
                        endcase
                    end
                    exp_q.push_back(mk(0, hr, d, 1, 0));
                end
            end
        end
        exp_q.push_back(mk(0, 0, 0, 0, 1));
        exp_q.push_back(mk(0, 0, 0, 0, 0));
        exp_q.push_back(mk(0, 0, 0, 0, 0));
    endtask

    task automatic set_cfg(input cfg_t c);
        h_size    = CW'(c.h);
        v_size    = CW'(c.v);
        h_blank   = CW'(c.hb);
        v_blank   = CW'(c.vb);
        vsync_len = CW'(c.vs);
        frame_cnt = CW'(c.fc);
        mode      = 2'(c.md);
        const_val = DW'(c.cv);
    endtask

    function automatic bit pick(input int kind, input int cyc);
        if (kind == 0) return 1'b1;
        if (kind == 1) return (cyc % 4 == 3);
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic run(input string name, input cfg_t c, input int pe_kind,
                       input int stop_frame, input bit noise);
        int n;
        int idx;
        int cyc;
        int stop_at;
        int bound;
        bit pe;
        obs_t got;
        obs_t want;
        n = (c.fc != 0) ? c.fc : stop_frame + 1;
        build_model(c, n);
        stop_at = -1;
        if (stop_frame >= 0)
            stop_at = frame_start[stop_frame] + c.vs * (c.h + c.hb) + 1;
        bound = exp_q.size() * 8 + 50;
        @(negedge sys_clock);
        set_cfg(c);
        start = 1'b1;
        pix_en = 1'($urandom_range(0, 1));
        @(posedge sys_clock);
        #1;
        idx = 0;
        cyc = 0;
        got = sample();
        checks++;
        if (got !== exp_q[0] || cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL %s start: got %h err=%b want %h err=0",
                     name, got, cfg_err, exp_q[0]);
        end
        while (idx < exp_q.size() - 1 && cyc < bound) begin
            @(negedge sys_clock);
            start = 1'b0;
            stop = 1'b0;
            pe = pick(pe_kind, cyc);
            pix_en = pe;
            if (noise) begin
                h_size = CW'($urandom);
                v_size = CW'($urandom);
                h_blank = CW'($urandom);
                v_blank = CW'($urandom);
                vsync_len = CW'($urandom);
                frame_cnt = CW'($urandom);
                mode = 2'($urandom);
                const_val = DW'($urandom);
                if (exp_q[idx].bz && $urandom_range(0, 5) == 0)
                    start = 1'b1;
            end
            if (idx == stop_at)
                stop = 1'b1;
            @(posedge sys_clock);
            #1;
            if (pe) idx++;
            want = exp_q[idx];
            if (!pe) want.fd = 1'b0;
            got = sample();
            checks++;
            if (got !== want || cfg_err !== 1'b0) begin
                errors++;
                $display("FAIL %s tick %0d cyc %0d: got vs=%b hr=%b d=%0d bz=%b fd=%b err=%b want vs=%b hr=%b d=%0d bz=%b fd=%b err=0",
                         name, idx, cyc, got.vs, got.hr, got.d, got.bz, got.fd,
                         cfg_err, want.vs, want.hr, want.d, want.bz, want.fd);
            end
            cyc++;
        end
        checks++;
        if (idx < exp_q.size() - 1) begin
            errors++;
            $display("FAIL %s timeout: reached tick %0d required %0d",
                     name, idx, exp_q.size() - 1);
        end
        @(negedge sys_clock);
        start = 1'b0;
        stop = 1'b0;
        pix_en = 1'b0;
    endtask

    function automatic cfg_t base_cfg();
        cfg_t c;
        c.h = 4; c.v = 2; c.hb = 2; c.vb = 1; c.vs = 1;
        c.fc = 1; c.md = 0; c.cv = 0;
        return c;
    endfunction

    task automatic test_reset();
        #1 reset = 1'b0;
        #2;
        checks++;
        if (sample() !== mk(0, 0, 0, 0, 0) || cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got %h err=%b want all zero",
                     sample(), cfg_err);
        end
        repeat (2) @(posedge sys_clock);
        @(negedge sys_clock);
        reset = 1'b1;
        pix_en = 1'b1;
        repeat (4) begin
            @(posedge sys_clock);
            #1;
            checks++;
            if (busy !== 1'b0 || cmos_vsync !== 1'b0 || cmos_href !== 1'b0) begin
                errors++;
                $display("FAIL idle_after_reset: got busy=%b vs=%b hr=%b want 0 0 0",
                         busy, cmos_vsync, cmos_href);
            end
        end
    endtask

    task automatic test_basic();
        run("basic", base_cfg(), 0, -1, 1'b0);
    endtask

    task automatic test_continuous();
        cfg_t c;
        c = base_cfg();
        c.hb = 0; c.vb = 0; c.fc = 3;
        run("continuous", c, 0, -1, 1'b0);
    endtask

    task automatic test_stop();
        cfg_t c;
        c = base_cfg();
        c.fc = 0; c.md = 1;
        run("stop_mid_frame2", c, 0, 1, 1'b0);
    endtask

    task automatic test_pix_en_div4();
        cfg_t c;
        c = base_cfg();
        c.md = 2; c.fc = 2;
        run("pix_en_div4", c, 1, -1, 1'b0);
    endtask

    task automatic test_stop_idle();
        cfg_t c;
        c = base_cfg();
        c.fc = 2; c.md = 3; c.cv = 8'hA5;
        @(negedge sys_clock);
        stop = 1'b1;
        @(negedge sys_clock);
        stop = 1'b0;
        run("stop_in_idle", c, 0, -1, 1'b0);
    endtask

    task automatic test_cfg_err();
        cfg_t c;
        int which;
        for (int k = 0; k < 3; k++) begin
            c = base_cfg();
            which = k;
            if (which == 0) c.v = 0;
            if (which == 1) c.h = 0;
            if (which == 2) c.vs = 0;
            @(negedge sys_clock);
            set_cfg(c);
            start = 1'b1;
            pix_en = 1'b1;
            @(posedge sys_clock);
            #1;
            @(negedge sys_clock);
            start = 1'b0;
            repeat (3) begin
                @(posedge sys_clock);
                #1;
                checks++;
                if (cfg_err !== 1'b1 || busy !== 1'b0 || cmos_vsync !== 1'b0) begin
                    errors++;
                    $display("FAIL cfg_err_%0d: got err=%b busy=%b vs=%b want 1 0 0",
                             k, cfg_err, busy, cmos_vsync);
                end
            end
        end
        c = base_cfg();
        c.fc = 2; c.md = 0;
        run("valid_after_err_noise", c, 2, -1, 1'b1);
    endtask

    task automatic test_reset_mid();
        cfg_t c;
        int guard;
        c = base_cfg();
        c.md = 3; c.cv = 8'h3C; c.fc = 0;
        @(negedge sys_clock);
        set_cfg(c);
        start = 1'b1;
        pix_en = 1'b1;
        @(negedge sys_clock);
        start = 1'b0;
        guard = 0;
        while (cmos_href !== 1'b1 && guard < 100) begin
            @(negedge sys_clock);
            guard++;
        end
        checks++;
        if (cmos_href !== 1'b1 || cmos_data !== 8'h3C) begin
            errors++;
            $display("FAIL mid_active_reach: got hr=%b d=%h want 1 3c",
                     cmos_href, cmos_data);
        end
        @(posedge sys_clock);
        #2 reset = 1'b0;
        #1;
        checks++;
        if (sample() !== mk(0, 0, 0, 0, 0) || cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_active: got %h err=%b want all zero",
                     sample(), cfg_err);
        end
        @(negedge sys_clock);
        reset = 1'b1;
        repeat (3) begin
            @(posedge sys_clock);
            #1;
            checks++;
            if (busy !== 1'b0 || cmos_vsync !== 1'b0) begin
                errors++;
                $display("FAIL idle_after_mid_reset: got busy=%b vs=%b want 0 0",
                         busy, cmos_vsync);
            end
        end
        pix_en = 1'b0;
    endtask

    task automatic test_random();
        cfg_t c;
        for (int r = 0; r < 10; r++) begin
            c.h  = $urandom_range(1, 6);
            c.hb = $urandom_range(0, 3);
            c.v  = $urandom_range(1, 4);
            c.vb = $urandom_range(0, 2);
            c.vs = $urandom_range(1, 2);
            c.fc = $urandom_range(1, 3);
            c.md = $urandom_range(0, 3);
            c.cv = $urandom_range(0, 255);
            run($sformatf("random_%0d", r), c, r % 3, -1, 1'(r % 2));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_continuous();
        test_stop();
        test_pix_en_div4();
        test_stop_idle();
        test_cfg_err();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
